// File: rtl/alu_src_pkg.sv
// Shared definitions for the ALU source-B operand stage: select encoding,
// default constants and the select-legality check.
package alu_src_pkg;

    typedef enum logic [2:0] {
        SRCB_REG     = 3'b000,
        SRCB_IMM     = 3'b010,
        SRCB_CONST_A = 3'b100,
        SRCB_CONST_B = 3'b110,
        SRCB_FB      = 3'b111
    } alu_src_b_e;

    localparam int unsigned CONST_A_DEFAULT = 32'd4;
    localparam int unsigned CONST_B_DEFAULT = 32'd12;

    function automatic logic is_legal_src_b(input logic [2:0] sel);
        case (sel)
            SRCB_REG, SRCB_IMM, SRCB_CONST_A, SRCB_CONST_B, SRCB_FB: is_legal_src_b = 1'b1;
            default:                                                  is_legal_src_b = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_src_b_stage_skid_buffer.sv
// Two-entry valid/ready buffer: a main output register backed by one skid
// register, so a registered in_ready never loses a request.
module skid_buffer #(
    parameter int unsigned DW = 36
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_data_q,  main_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;
    logic          in_ready_q;
    logic          accept_s;
    logic          main_free_s;

    assign accept_s    = in_valid && in_ready_q;
    // Main can take a new item if it is empty or its current item leaves this edge.
    assign main_free_s = !main_valid_q || out_ready;

    // Next-state for main and skid registers.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (main_free_s) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // State registers; reset discards any in-flight items.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/alu_src_b_stage.sv
// Registered ALU source-B select with feedback capture/bypass, illegal-select
// detection and a skid-buffered valid/ready output.
module alu_src_b_stage
    import alu_src_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned CONST_A   = CONST_A_DEFAULT,
    parameter int unsigned CONST_B   = CONST_B_DEFAULT,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           alu_src_b,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [WIDTH-1:0]     imm_ext,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_result_valid,
    input  logic [TAG_W-1:0]     tag_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     src_b_out,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 illegal_sel,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    logic [WIDTH-1:0]       fb_q;
    logic [WIDTH-1:0]       operand_s;
    logic [TAG_W+WIDTH-1:0] out_data_s;
    logic                   accept_s;
    logic                   illegal_accept_s;
    logic                   illegal_q;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    assign accept_s         = in_valid && in_ready;
    assign illegal_accept_s = accept_s && !is_legal_src_b(alu_src_b);

    // Operand select; feedback bypasses fb_q when a fresh result arrives this cycle.
    always_comb begin
        operand_s = '0;
        case (alu_src_b)
            SRCB_REG:     operand_s = b_in;
            SRCB_IMM:     operand_s = imm_ext;
            SRCB_CONST_A: operand_s = WIDTH'(CONST_A);
            SRCB_CONST_B: operand_s = WIDTH'(CONST_B);
            SRCB_FB: begin
                if (alu_result_valid) begin
                    operand_s = alu_result;
                end else begin
                    operand_s = fb_q;
                end
            end
            default:      operand_s = '0;
        endcase
    end

    // Saturating illegal-request counter.
    always_comb begin
        if (illegal_accept_s && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Feedback capture and error reporting registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_q        <= '0;
            illegal_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (alu_result_valid) begin
                fb_q <= alu_result;
            end
            illegal_q   <= illegal_accept_s;
            err_count_q <= err_count_d;
        end
    end

    skid_buffer #(
        .DW (TAG_W + WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({tag_in, operand_s}),
        .out_valid (out_valid),
        .out_data  (out_data_s),
        .out_ready (out_ready)
    );

    assign src_b_out   = out_data_s[WIDTH-1:0];
    assign tag_out     = out_data_s[TAG_W+WIDTH-1:WIDTH];
    assign illegal_sel = illegal_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed self-checking bench for alu_src_b_stage with hand-computed expectations.
module tb_alu_src_b_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  alu_src_b;
    logic [31:0] b_in, imm_ext, alu_result;
    logic        alu_result_valid;
    logic [3:0]  tag_in;
    logic        in_valid, in_ready;
    logic [31:0] src_b_out;
    logic [3:0]  tag_out;
    logic        out_valid, out_ready;
    logic        illegal_sel;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_src_b_stage dut (
        .clk              (clk),
        .reset            (reset),
        .alu_src_b        (alu_src_b),
        .b_in             (b_in),
        .imm_ext          (imm_ext),
        .alu_result       (alu_result),
        .alu_result_valid (alu_result_valid),
        .tag_in           (tag_in),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .src_b_out        (src_b_out),
        .tag_out          (tag_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .illegal_sel      (illegal_sel),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; alu_src_b = 3'b000; b_in = 32'h0; imm_ext = 32'h0;
        alu_result = 32'h0; alu_result_valid = 1'b0; tag_in = 4'h0;
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (src_b_out !== 32'h0) begin n_fail++; $display("FAIL reset_src_b got=%h exp=0", src_b_out); end
        n_checks++; if (err_count !== 8'd0 || illegal_sel !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0d/%b exp=0/0", err_count, illegal_sel); end
        reset = 1'b0;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        alu_src_b = 3'b010; imm_ext = 32'h0000_0ABC; tag_in = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        n_checks++; if (src_b_out !== 32'h0000_0ABC) begin n_fail++; $display("FAIL single_data got=%h exp=00000abc", src_b_out); end
        n_checks++; if (tag_out !== 4'd3) begin n_fail++; $display("FAIL single_tag got=%0d exp=3", tag_out); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        alu_src_b = 3'b100; tag_in = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        n_checks++; if (src_b_out !== 32'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_const_a got=%h/%b exp=4/1", src_b_out, out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
        alu_src_b = 3'b110; tag_in = 4'd2;
        step();
        in_valid = 1'b0;
        n_checks++; if (src_b_out !== 32'd12 || out_valid !== 1'b1 || tag_out !== 4'd2) begin n_fail++; $display("FAIL b2b_const_b got=%h/%b/%0d exp=c/1/2", src_b_out, out_valid, tag_out); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got=%b exp=1", in_ready); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; alu_src_b = 3'b000; in_valid = 1'b1;
        b_in = 32'h11; tag_in = 4'd1;
        step();
        n_checks++; if (in_ready !== 1'b1 || src_b_out !== 32'h11) begin n_fail++; $display("FAIL bp_first got=%b/%h exp=1/11", in_ready, src_b_out); end
        b_in = 32'h22; tag_in = 4'd2;
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        b_in = 32'h33; tag_in = 4'd3;
        step();
        n_checks++; if (src_b_out !== 32'h11 || out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold got=%h/%b/%b exp=11/1/0", src_b_out, out_valid, in_ready); end
        out_ready = 1'b1;
        step();
        n_checks++; if (src_b_out !== 32'h22 || tag_out !== 4'd2 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second got=%h/%0d/%b exp=22/2/1", src_b_out, tag_out, in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (src_b_out !== 32'h33 || tag_out !== 4'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third got=%h/%0d/%b exp=33/3/1", src_b_out, tag_out, out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_feedback();
        alu_result = 32'hDEAD_BEEF; alu_result_valid = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step();
        alu_result_valid = 1'b0; alu_result = 32'h0; alu_src_b = 3'b111; in_valid = 1'b1;
        step();
        n_checks++; if (src_b_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fb_reg got=%h exp=deadbeef", src_b_out); end
        alu_result = 32'h1234; alu_result_valid = 1'b1;
        step();
        alu_result_valid = 1'b0; in_valid = 1'b0;
        n_checks++; if (src_b_out !== 32'h1234) begin n_fail++; $display("FAIL fb_bypass got=%h exp=1234", src_b_out); end
        step();
    endtask

    task automatic test_illegal();
        alu_src_b = 3'b101; b_in = 32'h55; tag_in = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (illegal_sel !== 1'b1 || err_count !== 8'd1) begin n_fail++; $display("FAIL ill_pulse got=%b/%0d exp=1/1", illegal_sel, err_count); end
        n_checks++; if (src_b_out !== 32'h0 || tag_out !== 4'd7 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_data got=%h/%0d/%b exp=0/7/1", src_b_out, tag_out, out_valid); end
        alu_src_b = 3'b001;
        step();
        n_checks++; if (illegal_sel !== 1'b0 || err_count !== 8'd1) begin n_fail++; $display("FAIL ill_idle got=%b/%0d exp=0/1", illegal_sel, err_count); end
        in_valid = 1'b1;
        for (int i = 0; i < 253; i++) begin
            alu_src_b = (i % 2 == 0) ? 3'b001 : 3'b011;
            step();
        end
        n_checks++; if (err_count !== 8'd254) begin n_fail++; $display("FAIL ill_254 got=%0d exp=254", err_count); end
        step();
        n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL ill_255 got=%0d exp=255", err_count); end
        for (int i = 0; i < 46; i++) begin
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (err_count !== 8'd255 || illegal_sel !== 1'b1) begin n_fail++; $display("FAIL ill_sat got=%0d/%b exp=255/1", err_count, illegal_sel); end
        step();
    endtask

    task automatic test_reset_mid();
        alu_result = 32'hCAFE_0001; alu_result_valid = 1'b1;
        out_ready = 1'b0; alu_src_b = 3'b000; in_valid = 1'b1; b_in = 32'hA1; tag_in = 4'd9;
        step();
        alu_result_valid = 1'b0; b_in = 32'hA2;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0 || src_b_out !== 32'hA1) begin n_fail++; $display("FAIL rm_full got=%b/%h exp=0/a1", in_ready, src_b_out); end
        reset = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0 || src_b_out !== 32'h0 || tag_out !== 4'd0) begin
            n_fail++; $display("FAIL rm_reset got=%b/%0d/%b/%h/%0d exp=0/0/0/0/0", out_valid, err_count, in_ready, src_b_out, tag_out);
        end
        reset = 1'b0; out_ready = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_after got=%b/%b exp=1/0", in_ready, out_valid); end
        alu_src_b = 3'b111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (src_b_out !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_fb_cleared got=%h/%b exp=0/1", src_b_out, out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_feedback();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
